// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg: shared types and elaboration helpers for the iterative
// fixed-point square root (state encoding, derived sizes, parameter checks).
package fp_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Root bits produced: half of the scaled operand width.
  function automatic int unsigned iter_of(input int unsigned width,
                                          input int unsigned frac_width);
    return (width + frac_width) / 2;
  endfunction

  // Clock cycles spent in BUSY per operation.
  function automatic int unsigned cycles_of(input int unsigned width,
                                            input int unsigned frac_width,
                                            input int unsigned steps);
    return iter_of(width, frac_width) / steps;
  endfunction

  // Step counter width; at least one bit even for a single-cycle core.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  // Legal configurations: even scaled width, 1/2/4 steps dividing the
  // iteration count, and a rounded root that still fits in WIDTH.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned frac_width,
                                   input int unsigned steps);
    int unsigned iter;
    iter = iter_of(width, frac_width);
    return (width > 0) &&
           (frac_width <= width) &&
           (((width + frac_width) % 2) == 0) &&
           ((steps == 1) || (steps == 2) || (steps == 4)) &&
           (iter >= steps) &&
           ((iter % steps) == 0) &&
           (iter < width + 1);
  endfunction

endpackage

// File: rtl/fp_sqrt_iter_if.sv
// fp_sqrt_iter_if: operand/result handshake bundle for fp_sqrt_iter.
//   in_valid/in_ready/in    : operand channel (producer -> unit)
//   out_valid/out_ready/out : result channel (unit -> consumer)
//   rem                     : unrounded remainder, ITER+1 bits
//   busy                    : unit is iterating
// master: the side feeding operands and taking results; slave: the sqrt unit.
interface fp_sqrt_iter_if
  import fp_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FRAC_WIDTH = 0
);
  localparam int unsigned REM_W = iter_of(WIDTH, FRAC_WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [REM_W-1:0] rem;
  logic             busy;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, rem, busy
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, rem, busy
  );

endinterface

// File: rtl/fp_sqrt_step.sv
// fp_sqrt_step: one combinational restoring square-root recurrence step.
//   acc/q      : partial remainder (ITER+2 bits) and partial root (ITER bits)
//   bits       : next two operand bits, MSB first
//   acc_next   : updated remainder
//   q_next     : root shifted left with the new digit
module fp_sqrt_step #(
  parameter int unsigned ITER = 16
) (
  input  logic [ITER+1:0] acc,
  input  logic [ITER-1:0] q,
  input  logic [1:0]      bits,
  output logic [ITER+1:0] acc_next,
  output logic [ITER-1:0] q_next
);

  localparam int unsigned TW = ITER + 4;

  logic [TW-1:0] trial;
  logic [TW-1:0] sub;
  logic [TW-1:0] diff;
  logic          ge;

  // Trial subtraction of 4q+1; keep it only if it does not go negative.
  // The remainder never exceeds 2q, so narrowing to ITER+2 bits is lossless.
  always_comb begin
    trial    = {acc, bits};
    sub      = TW'({q, 2'b01});
    diff     = trial - sub;
    ge       = (trial >= sub);
    acc_next = (ITER+2)'(ge ? diff : trial);
    q_next   = ITER'({q, ge});
  end

endmodule

// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: iterative unsigned fixed-point square root with
// valid/ready handshakes, STEPS_PER_CYCLE root bits resolved per clock.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset; aborts any operation in flight
//   bus   : fp_sqrt_iter_if.slave (operand in, result out, rem, busy)
// out = floor(sqrt(in * 2^FRAC_WIDTH)) in the format of in; rem is the
// unrounded remainder. Define FP_SQRT_ROUND_EN to round out to nearest.
module fp_sqrt_iter
  import fp_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned FRAC_WIDTH      = 0,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input logic         clk,
  input logic         reset,
  fp_sqrt_iter_if.slave bus
);

  localparam int unsigned ITER   = iter_of(WIDTH, FRAC_WIDTH);
  localparam int unsigned CYCLES = cycles_of(WIDTH, FRAC_WIDTH, STEPS_PER_CYCLE);
  localparam int unsigned CNT_W  = cnt_width(CYCLES);
  localparam int unsigned ACC_W  = ITER + 2;
  localparam int unsigned XW     = 2 * ITER;
  localparam int unsigned SH     = 2 * STEPS_PER_CYCLE;

  if (!params_ok(WIDTH, FRAC_WIDTH, STEPS_PER_CYCLE)) begin : g_bad_params
    $error("fp_sqrt_iter: illegal WIDTH/FRAC_WIDTH/STEPS_PER_CYCLE combination");
  end

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [XW-1:0]    x;
  logic [ITER-1:0]  q;
  logic [CNT_W-1:0] cnt;

  // Chain of recurrence steps; step i consumes operand bits below step i-1.
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    logic [ACC_W-1:0] acc_i;
    logic [ACC_W-1:0] acc_o;
    logic [ITER-1:0]  q_i;
    logic [ITER-1:0]  q_o;

    if (i == 0) begin : g_first
      assign acc_i = acc;
      assign q_i   = q;
    end else begin : g_next
      assign acc_i = g_step[i-1].acc_o;
      assign q_i   = g_step[i-1].q_o;
    end

    fp_sqrt_step #(
      .ITER (ITER)
    ) u_step (
      .acc      (acc_i),
      .q        (q_i),
      .bits     (x[XW-1-2*i -: 2]),
      .acc_next (acc_o),
      .q_next   (q_o)
    );
  end

  logic [ACC_W-1:0] acc_f;
  logic [ITER-1:0]  q_f;
  logic [WIDTH-1:0] res_c;

  assign acc_f = g_step[STEPS_PER_CYCLE-1].acc_o;
  assign q_f   = g_step[STEPS_PER_CYCLE-1].q_o;

  // Remainder above q means the true root is past q + 0.5; ties cannot occur.
`ifdef FP_SQRT_ROUND_EN
  assign res_c = (acc_f > ACC_W'(q_f)) ? WIDTH'(q_f) + WIDTH'(1) : WIDTH'(q_f);
`else
  assign res_c = WIDTH'(q_f);
`endif

  // Control FSM and datapath registers; all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      x             <= '0;
      q             <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.rem       <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc          <= '0;
            x            <= XW'(bus.in) << FRAC_WIDTH;
            q            <= '0;
            cnt          <= '0;
            state        <= BUSY;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        BUSY: begin
          acc <= acc_f;
          q   <= q_f;
          x   <= x << SH;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CYCLES - 1)) begin
            bus.out       <= res_c;
            bus.rem       <= (ITER+1)'(acc_f);
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: directed table-driven bench for fp_sqrt_iter.
// Three configurations: A = 32/0 one step, B = 32/0 four steps,
// C = 16/8 two steps. Hand sequences cover backpressure and mid-op reset.
module tb_fp_sqrt_iter;

  localparam int BUDGET = 100;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  int cyc_of [3] = '{16, 4, 6};

  fp_sqrt_iter_if #(.WIDTH(32), .FRAC_WIDTH(0)) if_a ();
  fp_sqrt_iter_if #(.WIDTH(32), .FRAC_WIDTH(0)) if_b ();
  fp_sqrt_iter_if #(.WIDTH(16), .FRAC_WIDTH(8)) if_c ();

  fp_sqrt_iter #(.WIDTH(32), .FRAC_WIDTH(0), .STEPS_PER_CYCLE(1)) u_a (
    .clk (clk), .reset (reset), .bus (if_a)
  );
  fp_sqrt_iter #(.WIDTH(32), .FRAC_WIDTH(0), .STEPS_PER_CYCLE(4)) u_b (
    .clk (clk), .reset (reset), .bus (if_b)
  );
  fp_sqrt_iter #(.WIDTH(16), .FRAC_WIDTH(8), .STEPS_PER_CYCLE(2)) u_c (
    .clk (clk), .reset (reset), .bus (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [63:0] val;
    logic [63:0] q;
    logic [63:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [63:0] d);
    case (w)
      0: begin if_a.in_valid = v; if_a.in = 32'(d); end
      1: begin if_b.in_valid = v; if_b.in = 32'(d); end
      default: begin if_c.in_valid = v; if_c.in = 16'(d); end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic r);
    case (w)
      0: if_a.out_ready = r;
      1: if_b.out_ready = r;
      default: if_c.out_ready = r;
    endcase
  endtask

  function automatic logic [63:0] rd_out(input int w);
    case (w)
      0: return 64'(if_a.out);
      1: return 64'(if_b.out);
      default: return 64'(if_c.out);
    endcase
  endfunction

  function automatic logic [63:0] rd_rem(input int w);
    case (w)
      0: return 64'(if_a.rem);
      1: return 64'(if_b.rem);
      default: return 64'(if_c.rem);
    endcase
  endfunction

  function automatic logic rd_valid(input int w);
    case (w)
      0: return if_a.out_valid;
      1: return if_b.out_valid;
      default: return if_c.out_valid;
    endcase
  endfunction

  function automatic logic rd_ready(input int w);
    case (w)
      0: return if_a.in_ready;
      1: return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  function automatic logic rd_busy(input int w);
    case (w)
      0: return if_a.busy;
      1: return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  // Expected result word from the floor root and its remainder.
  function automatic logic [63:0] exp_out(input logic [63:0] q, input logic [63:0] r);
`ifdef FP_SQRT_ROUND_EN
    return (r > q) ? q + 64'd1 : q;
`else
    return q;
`endif
  endfunction

  task automatic wait_valid(input int w, output int n);
    n = 0;
    while (!rd_valid(w) && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("dut%0d out_valid timeout", w), 64'(n >= BUDGET), 64'd0);
  endtask

  // Full handshake: offer, accept, wait for result, check latency, release.
  task automatic run_raw(input int w, input logic [63:0] val, input string tag,
                         output logic [63:0] o, output logic [63:0] r);
    int n;
    n = 0;
    while (!rd_ready(w) && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " in_ready before accept"}, 64'(rd_ready(w)), 64'd1);
    drive(w, 1'b1, val);
    @(posedge clk); #1;
    drive(w, 1'b0, 64'($urandom()));
    check({tag, " busy after accept"}, 64'(rd_busy(w)), 64'd1);
    check({tag, " in_ready after accept"}, 64'(rd_ready(w)), 64'd0);
    wait_valid(w, n);
    check({tag, " latency"}, 64'(n), 64'(cyc_of[w]));
    o = rd_out(w);
    r = rd_rem(w);
    check({tag, " busy in DONE"}, 64'(rd_busy(w)), 64'd0);
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
    check({tag, " out_valid drops"}, 64'(rd_valid(w)), 64'd0);
    check({tag, " in_ready back"}, 64'(rd_ready(w)), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] o;
    logic [63:0] r;
    string tag;
    tag = $sformatf("dut%0d in=0x%0h", v.w, v.val);
    run_raw(v.w, v.val, tag, o, r);
    check({tag, " out"}, o, exp_out(v.q, v.r));
    check({tag, " rem"}, r, v.r);
  endtask

  // Checks the root definition directly rather than a reference algorithm.
  task automatic run_prop(input int w, input logic [63:0] val, input int frac);
    logic [63:0] o;
    logic [63:0] r;
    logic [63:0] v;
    logic [63:0] q;
    string tag;
    tag = $sformatf("dut%0d rand in=0x%0h", w, val);
    v = val << frac;
    run_raw(w, val, tag, o, r);
    q = (o * o > v) ? o - 64'd1 : o;
    check({tag, " q^2<=v"}, 64'(q * q <= v), 64'd1);
    check({tag, " v<(q+1)^2"}, 64'(v < (q + 64'd1) * (q + 64'd1)), 64'd1);
    check({tag, " rem"}, r, v - q * q);
    check({tag, " out"}, o, exp_out(q, r));
  endtask

  initial begin
    logic [63:0] o;
    logic [63:0] r;
    int n;
    bit saw;

    reset = 1'b1;
    for (int w = 0; w < 3; w++) begin
      drive(w, 1'b0, 64'd0);
      set_ordy(w, 1'b0);
    end

    vecs.push_back('{0, 64'd144,        64'd12,    64'd0});
    vecs.push_back('{0, 64'hFFFFFFFF,   64'd65535, 64'd131070});
    vecs.push_back('{0, 64'd0,          64'd0,     64'd0});
    vecs.push_back('{0, 64'd1,          64'd1,     64'd0});
    vecs.push_back('{0, 64'd2,          64'd1,     64'd1});
    vecs.push_back('{0, 64'd3,          64'd1,     64'd2});
    vecs.push_back('{0, 64'd99,         64'd9,     64'd18});
    vecs.push_back('{0, 64'd1000000,    64'd1000,  64'd0});
    vecs.push_back('{0, 64'h80000000,   64'd46340, 64'd88048});
    vecs.push_back('{0, 64'd65535,      64'd255,   64'd510});
    vecs.push_back('{1, 64'd144,        64'd12,    64'd0});
    vecs.push_back('{1, 64'hFFFFFFFF,   64'd65535, 64'd131070});
    vecs.push_back('{1, 64'h80000000,   64'd46340, 64'd88048});
    vecs.push_back('{1, 64'd0,          64'd0,     64'd0});
    vecs.push_back('{1, 64'd65535,      64'd255,   64'd510});
    vecs.push_back('{2, 64'h0200,       64'd362,   64'd28});
    vecs.push_back('{2, 64'h0400,       64'd512,   64'd0});
    vecs.push_back('{2, 64'hFFFF,       64'd4095,  64'd7935});
    vecs.push_back('{2, 64'h0300,       64'd443,   64'd359});
    vecs.push_back('{2, 64'h0001,       64'd16,    64'd0});
    vecs.push_back('{2, 64'h0000,       64'd0,     64'd0});

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("dut%0d reset in_ready", w), 64'(rd_ready(w)), 64'd1);
      check($sformatf("dut%0d reset out_valid", w), 64'(rd_valid(w)), 64'd0);
      check($sformatf("dut%0d reset busy", w), 64'(rd_busy(w)), 64'd0);
      check($sformatf("dut%0d reset out", w), rd_out(w), 64'd0);
      check($sformatf("dut%0d reset rem", w), rd_rem(w), 64'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held while out_ready is low, extra operands ignored.
    drive(0, 1'b1, 64'd144);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'd81);
    wait_valid(0, n);
    check("bp latency", 64'(n), 64'd16);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d out", i), rd_out(0), exp_out(64'd12, 64'd0));
      check($sformatf("bp hold%0d rem", i), rd_rem(0), 64'd0);
      check($sformatf("bp hold%0d in_ready", i), 64'(rd_ready(0)), 64'd0);
      @(posedge clk); #1;
      check($sformatf("bp hold%0d out_valid", i), 64'(rd_valid(0)), 64'd1);
    end
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    check("bp out_valid drop", 64'(rd_valid(0)), 64'd0);
    check("bp in_ready after drop", 64'(rd_ready(0)), 64'd1);
    check("bp busy after drop", 64'(rd_busy(0)), 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0);
    check("bp second accepted busy", 64'(rd_busy(0)), 64'd1);
    wait_valid(0, n);
    check("bp second latency", 64'(n), 64'd16);
    check("bp second out", rd_out(0), exp_out(64'd9, 64'd0));
    check("bp second rem", rd_rem(0), 64'd0);
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);

    // Reset during the seventh BUSY cycle aborts the operation.
    drive(0, 1'b1, 64'd1000000);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort in_ready", 64'(rd_ready(0)), 64'd1);
    check("abort busy", 64'(rd_busy(0)), 64'd0);
    check("abort out_valid", 64'(rd_valid(0)), 64'd0);
    check("abort out", rd_out(0), 64'd0);
    check("abort rem", rd_rem(0), 64'd0);
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rd_valid(0)) saw = 1'b1;
    end
    check("abort no out_valid", 64'(saw), 64'd0);
    run_raw(0, 64'd81, "after abort", o, r);
    check("after abort out", o, exp_out(64'd9, 64'd0));
    check("after abort rem", r, 64'd0);

    // Random operands checked against the root definition.
    for (int i = 0; i < 60; i++) run_prop(0, 64'($urandom()), 0);
    for (int i = 0; i < 60; i++) run_prop(1, 64'($urandom()), 0);
    for (int i = 0; i < 60; i++) run_prop(2, 64'($urandom_range(65535)), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
